// File: rtl/fetch_queue.sv
// fetch_queue: owns the PC, issues 1-cycle-latency imem reads and buffers {inst, pc} for decode.
// Optional feature: define FETCH_HALT_ON_ZERO_EN to stop fetching on an all-zero instruction.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0100_0000,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic            halted
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] data_q [DEPTH];
    logic [XLEN-1:0] pc_q   [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_addr_q, inflight_addr_d;

    logic            pop;
    logic            push;
    logic            issue;
    logic            running;
    logic [CW-1:0]   credit_used;

`ifdef FETCH_HALT_ON_ZERO_EN
    typedef enum logic {RUN, HALT} state_e;
    state_e state_q, state_d;
    logic   halted_q;
    logic   halt_hit;

    assign running = (state_q == RUN);
    assign halted  = halted_q;
`else
    assign running = 1'b1;
    assign halted  = 1'b0;
`endif

    assign inst_valid = (count_q != '0);
    assign inst_data  = data_q[rd_ptr_q];
    assign inst_pc    = pc_q[rd_ptr_q];
    assign imem_addr  = fetch_pc_q;
    assign imem_req   = issue;

    always_comb begin
        pop         = inst_valid && inst_ready;
        // Entries queued plus the read still in flight, less the one leaving this cycle.
        credit_used = count_q + CW'(inflight_q) - CW'(pop);
        issue       = !reset && running && !redirect && (credit_used < CW'(DEPTH));

`ifdef FETCH_HALT_ON_ZERO_EN
        push     = inflight_q && running && !redirect && (imem_rdata != '0);
        halt_hit = inflight_q && running && !redirect && (imem_rdata == '0);
        state_d  = state_q;
        if (redirect) begin
            state_d = RUN;
        end else if (halt_hit) begin
            state_d = HALT;
        end
`else
        push = inflight_q && !redirect;
`endif

        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end

        inflight_d      = issue;
        inflight_addr_d = issue ? fetch_pc_q : inflight_addr_q;

        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q      <= RESET_PC;
            count_q         <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
`ifdef FETCH_HALT_ON_ZERO_EN
            state_q  <= RUN;
            halted_q <= 1'b0;
`endif
        end else begin
            fetch_pc_q      <= fetch_pc_d;
            count_q         <= count_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
            if (push) begin
                data_q[wr_ptr_q] <= imem_rdata;
                pc_q[wr_ptr_q]   <= inflight_addr_q;
            end
`ifdef FETCH_HALT_ON_ZERO_EN
            state_q  <= state_d;
            halted_q <= (state_d == HALT);
`endif
        end
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised fetch unit that replaces the single-register PC mux of the single-cycle core. It owns the PC, issues requests to instruction memory (1-cycle read latency), buffers returned instructions with their PCs in a DEPTH-entry FIFO, and hands them to decode over a valid/ready handshake. It sits between `memory` (imem) and `fetch_decode` and is the first step toward a pipelined core. A branch/jump redirect flushes the queue and any in-flight read.

## Interface
- XLEN, 32, PC and instruction width
- RESET_PC, 32'h01000000, first fetch address after reset
- DEPTH, 4, FIFO entries (power of two, ≥2)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  read request this cycle
- imem_addr  out  XLEN  read address, valid when imem_req=1
- imem_rdata  in  XLEN  read data, valid the cycle after a request
- redirect  in  1  taken branch/jump from execute
- redirect_pc  in  XLEN  new fetch target, valid with redirect
- inst_valid  out  1  head entry valid
- inst_ready  in  1  decode accepts head entry
- inst_data  out  XLEN  head instruction
- inst_pc  out  XLEN  PC of head instruction
- halted  out  1  fetch stopped on all-zero instruction (see Configuration)

## Operation
- Registers: fetch_pc, FIFO (data+pc), count (0..DEPTH), inflight (1 bit, with captured addr), state {RUN, HALT}.
- Issue: in RUN, imem_req=1 when count + inflight − pop < DEPTH and no redirect this cycle; imem_addr=fetch_pc; fetch_pc advances by 4 on issue. Addition mod 2^XLEN (wraps).
- Return: cycle after issue, {imem_rdata, captured addr} pushed to FIFO tail; inflight clears unless a new issue that cycle.
- Pop: inst_valid && inst_ready removes head. Push and pop in the same cycle: count unchanged, both pointers advance. Push into full FIFO cannot occur (credit rule); a bench assertion checks it.
- Redirect (priority over everything except reset): count←0, pointers←0, in-flight response discarded (squash flag on returning data), fetch_pc←redirect_pc, imem_req=0 that cycle; first request to redirect_pc next cycle. Redirect in HALT returns state to RUN.
- inst_data/inst_pc held stable while inst_valid=1 and inst_ready=0.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0, halted=0, count=0, inflight=0, fetch_pc=RESET_PC, state=RUN. Reset asserted mid-operation discards FIFO and in-flight read immediately.
- First cycle after reset deasserts: imem_req=1, imem_addr=RESET_PC.
- Fetch-to-valid latency: 2 cycles (request cycle N, data registered into FIFO end of N+1, inst_valid=1 in N+2).
- Redirect-to-valid latency: 3 cycles from redirect cycle.
- Steady state with inst_ready=1: one instruction per cycle.
- inst_ready=0 with FIFO full: imem_req=0 until a pop; issue resumes the cycle of the pop.

## Configuration
- FETCH_HALT_ON_ZERO_EN defined: a returning (unsquashed) instruction equal to 0 is not pushed; state→HALT, halted=1 from next cycle, imem_req=0 while in HALT; entries already queued still drain. Leaves HALT only on reset or redirect.
- Undefined: 0 is queued like any instruction; halted tied to 0; HALT state absent.

## Test plan
- Reset then inst_ready=1, imem returns addr-derived data: imem_addr 0x01000000,0x01000004,… one per cycle; inst_valid first high 2 cycles after reset release, inst_pc 0x01000000.
- inst_ready=0 for 10 cycles: exactly DEPTH=4 requests issued, count=4, imem_req=0 thereafter; release ready -> 4 pops in order then stream resumes, no gaps or duplicates.
- Redirect to 0x01000040 while FIFO holds 3 entries and one read in flight: next inst_pc is 0x01000040, 3 cycles later; squashed data never appears.
- Redirect coincident with pop and push on same cycle: FIFO empty next cycle, no spurious inst_valid.
- fetch_pc = 0xFFFFFFFC: next request address 0x00000000.
- With FETCH_HALT_ON_ZERO_EN, imem returns 0 at 0x01000008: two valid instructions delivered, halted=1, imem_req stays 0; redirect to 0x01000000 resumes fetch and clears halted.
